// File: rtl/interrupt_ctrl_if.sv
// Register-write / request / presentation bundle for interrupt_ctrl.
// master drives requests, writes and ack; slave (the controller) returns state.
interface interrupt_ctrl_if #(
  parameter int NUM_CH = 8,
  parameter int ID_W   = 3
);
  logic [NUM_CH-1:0] irq_src;
  logic              wr_en;
  logic [1:0]        wr_addr;
  logic [NUM_CH-1:0] wr_data;
  logic              ack;
  logic              irq;
  logic [ID_W-1:0]   irq_id;
  logic [NUM_CH-1:0] pending;
  logic [NUM_CH-1:0] enable;

  modport master (
    output irq_src, wr_en, wr_addr, wr_data, ack,
    input  irq, irq_id, pending, enable
  );

  modport slave (
    input  irq_src, wr_en, wr_addr, wr_data, ack,
    output irq, irq_id, pending, enable
  );
endinterface

// File: rtl/interrupt_ctrl.sv
// Fixed-priority interrupt controller: sticky pending, enable mask, IDLE/ASSERT/GAP presentation.
// Define INTR_EDGE_DETECT_EN for rising-edge source events; default treats sources as level.
module interrupt_ctrl #(
  parameter int NUM_CH = 8,
  parameter int ID_W   = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  interrupt_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ASSERT = 2'd1,
    S_GAP    = 2'd2
  } state_t;

  localparam logic [1:0] A_ENABLE = 2'd0;
  localparam logic [1:0] A_SET    = 2'd1;
  localparam logic [1:0] A_CLEAR  = 2'd2;

  state_t            r_state;
  state_t            w_state_nx;
  logic              r_irq;
  logic              w_irq_nx;
  logic [ID_W-1:0]   r_irq_id;
  logic [ID_W-1:0]   w_id_nx;
  logic [NUM_CH-1:0] r_pending;
  logic [NUM_CH-1:0] r_enable;
  logic [NUM_CH-1:0] w_event;
  logic [NUM_CH-1:0] w_set;
  logic [NUM_CH-1:0] w_clr;
  logic [NUM_CH-1:0] w_ack_mask;
  logic [NUM_CH-1:0] w_pend_nx;
  logic [NUM_CH-1:0] w_en_nx;
  logic [NUM_CH-1:0] w_cand_vec;
  logic [ID_W-1:0]   w_cand_id;
  logic              w_cand_vld;
  logic              w_ack_acc;
  logic              w_keep;

`ifdef INTR_EDGE_DETECT_EN
  logic [NUM_CH-1:0] r_src_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_src_q <= '0;
    else     r_src_q <= bus.irq_src;
  end

  assign w_event = bus.irq_src & ~r_src_q;
`else
  assign w_event = bus.irq_src;
`endif

  // Ack only counts while an interrupt is actually being presented.
  assign w_ack_acc  = (r_state == S_ASSERT) && bus.ack;
  assign w_ack_mask = {{(NUM_CH-1){1'b0}}, 1'b1} << r_irq_id;

  assign w_set = w_event
               | ((bus.wr_en && bus.wr_addr == A_SET) ? bus.wr_data : '0);
  assign w_clr = ((bus.wr_en && bus.wr_addr == A_CLEAR) ? bus.wr_data : '0)
               | (w_ack_acc ? w_ack_mask : '0);

  // Set is applied after clear so a coincident event is never lost.
  assign w_pend_nx = (r_pending & ~w_clr) | w_set;
  assign w_en_nx   = (bus.wr_en && bus.wr_addr == A_ENABLE) ? bus.wr_data : r_enable;

  assign w_cand_vec = r_pending & r_enable;
  assign w_keep     = w_pend_nx[r_irq_id] & w_en_nx[r_irq_id];

  always_comb begin
    w_cand_id  = '0;
    w_cand_vld = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (w_cand_vec[i]) begin
        w_cand_id  = ID_W'(i);
        w_cand_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending <= '0;
      r_enable  <= '0;
    end else begin
      r_pending <= w_pend_nx;
      r_enable  <= w_en_nx;
    end
  end

  // Revocation looks at next-cycle pending/enable so irq drops on the edge that removes it.
  always_comb begin
    w_state_nx = r_state;
    w_irq_nx   = 1'b0;
    w_id_nx    = r_irq_id;
    case (r_state)
      S_IDLE: begin
        if (w_cand_vld) begin
          w_state_nx = S_ASSERT;
          w_irq_nx   = 1'b1;
          w_id_nx    = w_cand_id;
        end
      end
      S_ASSERT: begin
        if (bus.ack) begin
          w_state_nx = S_GAP;
        end else if (!w_keep) begin
          w_state_nx = S_IDLE;
        end else begin
          w_irq_nx   = 1'b1;
        end
      end
      S_GAP: begin
        w_state_nx = S_IDLE;
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_irq    <= 1'b0;
      r_irq_id <= '0;
    end else begin
      r_state  <= w_state_nx;
      r_irq    <= w_irq_nx;
      r_irq_id <= w_id_nx;
    end
  end

  assign bus.irq     = r_irq;
  assign bus.irq_id  = r_irq_id;
  assign bus.pending = r_pending;
  assign bus.enable  = r_enable;

endmodule

// File: doc/interrupt_ctrl.md
INTERRUPT_CTRL -- requirements
Module: interrupt_ctrl

Interface
REQ-001 SHALL have parameter NUM_CH, default 8: number of interrupt channels, legal range 2..32.
REQ-002 SHALL have parameter ID_W, default 3: channel ID width, equal to $clog2(NUM_CH).
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port irq_src, input, NUM_CH: per-channel hardware request.
REQ-006 SHALL have port wr_en, input, 1: register write strobe, one write per cycle.
REQ-007 SHALL have port wr_addr, input, 2: 0=ENABLE (write), 1=SET (W1S pending), 2=CLEAR (W1C pending), 3=reserved (ignored).
REQ-008 SHALL have port wr_data, input, NUM_CH: write payload.
REQ-009 SHALL have port ack, input, 1: consumer acknowledge of the presented interrupt.
REQ-010 SHALL have port irq, output, 1: registered interrupt line.
REQ-011 SHALL have port irq_id, output, ID_W: ID of the presented channel, valid while irq=1.
REQ-012 SHALL have port pending, output, NUM_CH: pending register.
REQ-013 SHALL have port enable, output, NUM_CH: enable mask register.

Function
REQ-014 SHALL set pending[i] sticky when the source event for channel i occurs (see REQ-029) or when a SET write has wr_data[i]=1.
REQ-015 SHALL clear pending[i] on a CLEAR write with wr_data[i]=1, or on ack accepted in ASSERT for i=irq_id.
REQ-016 SHALL give set priority over clear when both hit the same bit in one cycle, so no event is lost.
REQ-017 SHALL load enable<=wr_data on an ENABLE write; pending bits of disabled channels SHALL still set but SHALL NOT be presented.
REQ-018 SHALL select the candidate as the lowest-index i with pending[i]&enable[i] (fixed priority, channel 0 highest).
REQ-019 SHALL implement FSM IDLE, ASSERT, GAP: IDLE->ASSERT when a candidate exists, latching irq_id; ASSERT->GAP on ack; GAP->IDLE unconditionally after one cycle.
REQ-020 SHALL drive irq=1 only in ASSERT; irq and irq_id are registered outputs.
REQ-021 SHALL hold irq_id stable throughout ASSERT, even if a higher-priority channel becomes pending.
REQ-022 SHALL revoke the interrupt (ASSERT->IDLE, no ack) if pending[irq_id] or enable[irq_id] becomes 0 while in ASSERT.
REQ-023 SHALL ignore ack in IDLE and GAP.
REQ-024 SHALL have latency: source event in cycle N -> pending set visible N+1 -> irq=1 at N+2.
REQ-025 SHALL leave pending set if a new source event on the same channel coincides with ack, causing re-presentation after GAP.

Reset
REQ-026 SHALL on rst=1, asynchronously, clear pending and enable to 0, put the FSM in IDLE, and drive irq=0 and irq_id=0.
REQ-027 SHALL on reset mid-ASSERT drop irq immediately and discard the outstanding interrupt without requiring an ack.
REQ-028 SHALL on rst=1 reset the edge-detect history (REQ-029) to 0.

Configuration
REQ-029 SHALL treat source events according to macro INTR_EDGE_DETECT_EN: when defined, the event for channel i is a rising edge of irq_src[i] (registered previous value); when undefined, the event is any cycle with irq_src[i]=1 (level, re-sets pending every cycle held).

Verification
REQ-030 SHALL cover: NUM_CH=8, enable=0xFF, pulse irq_src[5] at cycle N -> pending=0x20 at N+1, irq=1 with irq_id=5 at N+2.
REQ-031 SHALL cover: pending 0x0A, enable 0xFF -> irq_id=1; ack -> GAP with irq=0 for one cycle -> irq_id=3 re-presented, pending=0x08.
REQ-032 SHALL cover: irq_id=3 presented, then SET 0x01 -> irq_id stays 3 until ack, then channel 0 is presented next.
REQ-033 SHALL cover: while presenting channel 2, write ENABLE=0xFB -> irq=0 next cycle with no ack, and pending[2] stays 1.
REQ-034 SHALL cover: CLEAR 0x10 in the same cycle as a channel-4 source event -> pending[4]=1 (set wins).
REQ-035 SHALL cover: with INTR_EDGE_DETECT_EN defined, irq_src[0] held high 5 cycles with ack after the first presentation -> exactly one presentation; with the macro undefined, channel 0 is re-presented after GAP.
